// File: rtl/ram_decode_pkg.sv
// Shared types and constants for the decode table block.
//   state_e        : sequencer states (INIT reloads the table, IDLE serves
//                    single reads, BURST streams auto-incrementing reads)
//   DEFAULT_TABLE  : the 16 legacy decode constants
//   default_entry(): reset-time contents of entry i, fitted to a data width
package ram_decode_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    BURST = 2'd2
  } state_e;

  localparam int TABLE_LEN = 16;

  localparam logic [7:0] DEFAULT_TABLE [TABLE_LEN] = '{
    8'h03, 8'h08, 8'h0D, 8'h14, 8'h19, 8'h1E, 8'h25, 8'h2A,
    8'h2C, 8'h31, 8'h36, 8'h3D, 8'h46, 8'h50, 8'h59, 8'h6C
  };

  // Entries past the legacy table are zero; narrow tables keep the low bits.
  function automatic logic [31:0] default_entry(input int unsigned i,
                                                input int unsigned data_w);
    logic [31:0] v;
    logic [31:0] mask;
    v    = (i < TABLE_LEN) ? {24'd0, DEFAULT_TABLE[i[3:0]]} : 32'd0;
    mask = (data_w >= 32) ? '1 : ((32'd1 << data_w) - 32'd1);
    return v & mask;
  endfunction

endpackage

// File: rtl/ram_decode_seq_if.sv
// Bus bundle for ram_decode_seq.
//   master : sequencing control side (drives enable, writes, read requests)
//   slave  : the decode table (returns read data, valid, busy, init_done)
interface ram_decode_seq_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              en;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] burst_len;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              init_done;

  modport master (
    output en, wr_en, wr_addr, wr_data, rd_req, rd_addr, burst_len,
    input  rd_valid, rd_data, busy, init_done
  );

  modport slave (
    input  en, wr_en, wr_addr, wr_data, rd_req, rd_addr, burst_len,
    output rd_valid, rd_data, busy, init_done
  );
endinterface

// File: rtl/ram_decode_mem.sv
// DEPTH x DATA_W table storage: one write port, one synchronous read port.
//   clk, rst_n : clock, async active-low reset (read register only)
//   we/wa/wd   : write strobe, address, data
//   re/ra      : read strobe, address
//   rdata      : registered read data; loads only on re, otherwise holds
// Read and write in the same cycle to the same address return the old word.
module ram_decode_mem #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_W;

  // The array itself is unreset; the init sequencer loads it after reset.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // Reset only on the output register so rd_data is never X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[ra];
  end
endmodule

// File: rtl/ram_decode_seq.sv
// Runtime-writable decode table with reset-time reload and burst readout.
//   clk, rst_n : rising-edge clock, async active-low reset
//   bus        : ram_decode_seq_if.slave
//     en              gates reads, user writes and burst progress
//     wr_en/addr/data user table write
//     rd_req/rd_addr  read start (IDLE only); burst_len extra words
//     rd_valid/data   read result, 1 cycle after issue
//     busy            high while loading the table or streaming a burst
//     init_done       table holds valid contents
module ram_decode_seq
  import ram_decode_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  ram_decode_seq_if.slave bus
);
  localparam int                DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

  state_e            state;
  logic [ADDR_W-1:0] init_ptr;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] remaining;
  logic              init_done_q;
  logic              rd_valid_q;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_ra;
  logic [DATA_W-1:0] mem_rdata;

  // Port steering: INIT owns the write port, user writes only outside INIT.
  always_comb begin
    mem_we = bus.en && bus.wr_en && (state != INIT);
    mem_wa = bus.wr_addr;
    mem_wd = bus.wr_data;
    mem_re = 1'b0;
    mem_ra = bus.rd_addr;
    case (state)
      INIT: begin
        mem_we = 1'b1;
        mem_wa = init_ptr;
        mem_wd = DATA_W'(default_entry(32'(init_ptr), DATA_W));
      end
      IDLE:  mem_re = bus.en && bus.rd_req;
      BURST: begin
        mem_re = bus.en;
        mem_ra = ptr;
      end
      default: ;
    endcase
  end

  // The first burst word is issued straight from IDLE, so BURST only has to
  // stream the remaining burst_len words starting at rd_addr+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INIT;
      init_ptr    <= '0;
      init_done_q <= 1'b0;
      ptr         <= '0;
      remaining   <= '0;
    end else begin
      case (state)
        INIT: begin
          init_ptr <= init_ptr + ONE;
          if (init_ptr == LAST) begin
            state       <= IDLE;
            init_done_q <= 1'b1;
          end
        end
        IDLE: begin
          if (bus.en && bus.rd_req && (bus.burst_len != '0)) begin
            state     <= BURST;
            ptr       <= bus.rd_addr + ONE;
            remaining <= bus.burst_len;
          end
        end
        BURST: begin
          if (bus.en) begin
            ptr       <= ptr + ONE;
            remaining <= remaining - ONE;
            if (remaining == ONE) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_valid_q <= 1'b0;
    else        rd_valid_q <= mem_re;
  end

  ram_decode_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .wa    (mem_wa),
    .wd    (mem_wd),
    .re    (mem_re),
    .ra    (mem_ra),
    .rdata (mem_rdata)
  );

  // busy falls on the edge that issues the last burst word, so it drops in
  // the same cycle that word shows up as rd_valid.
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = mem_rdata;
  assign bus.busy      = (state != IDLE);
  assign bus.init_done = init_done_q;
endmodule

// File: tb/tb_ram_decode_seq.sv
module tb_ram_decode_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ram_decode_seq_if #(.ADDR_W(4), .DATA_W(8))  bus  ();
  ram_decode_seq_if #(.ADDR_W(5), .DATA_W(12)) bus5 ();

  ram_decode_seq #(.ADDR_W(4), .DATA_W(8)) u_dut (
    .clk (clk), .rst_n (rst_n), .bus (bus)
  );
  ram_decode_seq #(.ADDR_W(5), .DATA_W(12)) u_dut5 (
    .clk (clk), .rst_n (rst_n), .bus (bus5)
  );

  typedef struct {
    logic [3:0] addr;
    logic [7:0] exp;
  } rd_vec_t;

  typedef struct {
    logic       en_nxt;
    logic       vld;
    logic [7:0] dat;
    logic       bsy;
  } step_t;

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_dat(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Single read on the 16x8 instance; leaves rd_req low afterwards.
  task automatic rd1(input string nm, input logic [3:0] a, input logic [7:0] e);
    bus.en = 1'b1; bus.rd_req = 1'b1; bus.rd_addr = a; bus.burst_len = 4'd0;
    @(negedge clk);
    chk_bit({nm, "_vld"}, bus.rd_valid, 1'b1);
    chk_dat({nm, "_dat"}, 12'(bus.rd_data), 12'(e));
    bus.rd_req = 1'b0;
    @(negedge clk);
    chk_bit({nm, "_drop"}, bus.rd_valid, 1'b0);
  endtask

  task automatic rd5(input string nm, input logic [4:0] a, input logic [11:0] e);
    bus5.en = 1'b1; bus5.rd_req = 1'b1; bus5.rd_addr = a; bus5.burst_len = 5'd0;
    @(negedge clk);
    chk_bit({nm, "_vld"}, bus5.rd_valid, 1'b1);
    chk_dat({nm, "_dat"}, bus5.rd_data, e);
    bus5.rd_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_init(input string nm, input int budget, input logic is5);
    int n = 0;
    while (!(is5 ? bus5.init_done : bus.init_done) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk_bit(nm, is5 ? bus5.init_done : bus.init_done, 1'b1);
  endtask

  rd_vec_t vt [6];
  step_t   st [8];
  logic [7:0]  wrap_dat [4];
  logic        wrap_bsy [4];
  logic [11:0] b5_dat [3];
  logic        b5_bsy [3];

  initial begin
    int busy_cnt;
    int vld_cnt;

    vt[0] = '{4'd0,  8'h03};
    vt[1] = '{4'd7,  8'h2A};
    vt[2] = '{4'd15, 8'h6C};
    vt[3] = '{4'd1,  8'h08};
    vt[4] = '{4'd10, 8'h36};
    vt[5] = '{4'd12, 8'h46};

    st[0] = '{1'b1, 1'b1, 8'h03, 1'b1};
    st[1] = '{1'b0, 1'b1, 8'h08, 1'b1};
    st[2] = '{1'b0, 1'b0, 8'h08, 1'b1};
    st[3] = '{1'b1, 1'b0, 8'h08, 1'b1};
    st[4] = '{1'b1, 1'b1, 8'h0D, 1'b1};
    st[5] = '{1'b1, 1'b1, 8'h14, 1'b1};
    st[6] = '{1'b1, 1'b1, 8'h19, 1'b1};
    st[7] = '{1'b1, 1'b1, 8'h1E, 1'b0};

    wrap_dat = '{8'h59, 8'h6C, 8'h03, 8'h08};
    wrap_bsy = '{1'b1, 1'b1, 1'b1, 1'b0};
    b5_dat   = '{12'h000, 12'h000, 12'h003};
    b5_bsy   = '{1'b1, 1'b1, 1'b0};

    {bus.en, bus.wr_en, bus.rd_req} = 3'b000;
    bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0; bus.burst_len = '0;
    {bus5.en, bus5.wr_en, bus5.rd_req} = 3'b000;
    bus5.wr_addr = '0; bus5.wr_data = '0; bus5.rd_addr = '0; bus5.burst_len = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_bit("rst_vld",   bus.rd_valid, 1'b0);
    chk_dat("rst_dat",   12'(bus.rd_data), 12'h000);
    chk_bit("rst_busy",  bus.busy, 1'b1);
    chk_bit("rst_idone", bus.init_done, 1'b0);
    chk_dat("rst5_dat",  bus5.rd_data, 12'h000);
    chk_bit("rst5_busy", bus5.busy, 1'b1);

    // INIT: 16 busy cycles; read and write attempts during INIT are dropped
    rst_n = 1'b1;
    busy_cnt = 0;
    vld_cnt = 0;
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) @(negedge clk);
      busy_cnt += int'(bus.busy);
      vld_cnt  += int'(bus.rd_valid);
      if (c == 15) chk_bit("init_done_early", bus.init_done, 1'b0);
      if (c == 3) begin
        bus.en = 1'b1; bus.rd_req = 1'b1; bus.rd_addr = 4'd2; bus.burst_len = 4'd3;
        bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 8'hFF;
      end
      if (c == 12) begin
        bus.rd_req = 1'b0; bus.wr_en = 1'b0;
      end
    end
    chk_dat("init_busy_cycles", 12'(busy_cnt), 12'd16);
    chk_bit("init_done", bus.init_done, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      busy_cnt += int'(bus.busy);
      vld_cnt  += int'(bus.rd_valid);
    end
    chk_dat("init_no_vld", 12'(vld_cnt), 12'd0);
    chk_dat("idle_no_stale_busy", 12'(busy_cnt), 12'd16);

    // Isolated single reads, then back-to-back single reads
    foreach (vt[i]) rd1($sformatf("rd%0d", vt[i].addr), vt[i].addr, vt[i].exp);
    bus.en = 1'b1; bus.burst_len = 4'd0;
    foreach (vt[i]) begin
      bus.rd_req = 1'b1; bus.rd_addr = vt[i].addr;
      @(negedge clk);
      chk_bit($sformatf("b2b%0d_vld", i), bus.rd_valid, 1'b1);
      chk_dat($sformatf("b2b%0d_dat", i), 12'(bus.rd_data), 12'(vt[i].exp));
    end
    bus.rd_req = 1'b0;
    @(negedge clk);

    // Wrapping burst: 14,15,0,1; rd_req held with other values is ignored
    bus.rd_req = 1'b1; bus.rd_addr = 4'd14; bus.burst_len = 4'd3;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_bit($sformatf("wrap%0d_vld", k), bus.rd_valid, 1'b1);
      chk_dat($sformatf("wrap%0d_dat", k), 12'(bus.rd_data), 12'(wrap_dat[k]));
      chk_bit($sformatf("wrap%0d_busy", k), bus.busy, wrap_bsy[k]);
      if (k == 0) begin bus.rd_addr = 4'd0; bus.burst_len = 4'd0; end
      if (k == 3) bus.rd_req = 1'b0;
    end
    @(negedge clk);
    chk_bit("wrap_end_vld", bus.rd_valid, 1'b0);
    chk_dat("wrap_end_hold", 12'(bus.rd_data), 12'h008);

    // Enable pause mid-burst; a write attempted while en=0 is blocked
    bus.rd_req = 1'b1; bus.rd_addr = 4'd0; bus.burst_len = 4'd5;
    foreach (st[k]) begin
      @(negedge clk);
      chk_bit($sformatf("pause%0d_vld", k), bus.rd_valid, st[k].vld);
      chk_dat($sformatf("pause%0d_dat", k), 12'(bus.rd_data), 12'(st[k].dat));
      chk_bit($sformatf("pause%0d_busy", k), bus.busy, st[k].bsy);
      bus.rd_req = 1'b0;
      bus.en = st[k].en_nxt;
      bus.wr_en = (k == 1); bus.wr_addr = 4'd9; bus.wr_data = 8'hEE;
    end
    bus.wr_en = 1'b0;

    // en=0 in IDLE: request ignored, data holds
    bus.en = 1'b0; bus.rd_req = 1'b1; bus.rd_addr = 4'd3; bus.burst_len = 4'd0;
    @(negedge clk);
    chk_bit("en0_vld", bus.rd_valid, 1'b0);
    chk_dat("en0_hold", 12'(bus.rd_data), 12'h01E);
    bus.rd_req = 1'b0;
    rd1("blocked_wr9", 4'd9, 8'h31);

    // Write and read same address in one cycle: old data, then new
    bus.en = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 8'hA5;
    bus.rd_req = 1'b1; bus.rd_addr = 4'd5; bus.burst_len = 4'd0;
    @(negedge clk);
    chk_dat("rfirst_old", 12'(bus.rd_data), 12'h01E);
    bus.wr_en = 1'b0;
    @(negedge clk);
    chk_dat("rfirst_new", 12'(bus.rd_data), 12'h0A5);
    bus.rd_req = 1'b0;
    @(negedge clk);

    // Write during BURST lands before the burst reaches it
    bus.rd_req = 1'b1; bus.rd_addr = 4'd4; bus.burst_len = 4'd2;
    @(negedge clk);
    chk_dat("bwr0_dat", 12'(bus.rd_data), 12'h019);
    bus.rd_req = 1'b0; bus.wr_en = 1'b1; bus.wr_addr = 4'd6; bus.wr_data = 8'h77;
    @(negedge clk);
    chk_dat("bwr1_dat", 12'(bus.rd_data), 12'h0A5);
    bus.wr_en = 1'b0;
    @(negedge clk);
    chk_dat("bwr2_dat", 12'(bus.rd_data), 12'h077);
    chk_bit("bwr2_busy", bus.busy, 1'b0);
    @(negedge clk);

    // Reset pulse reloads the defaults
    rst_n = 1'b0;
    @(negedge clk);
    chk_bit("rst2_busy", bus.busy, 1'b1);
    chk_bit("rst2_idone", bus.init_done, 1'b0);
    chk_dat("rst2_dat", 12'(bus.rd_data), 12'h000);
    rst_n = 1'b1;
    wait_init("reinit_wait", 40, 1'b0);
    rd1("reinit_rd5", 4'd5, 8'h1E);
    rd1("reinit_rd6", 4'd6, 8'h25);

    // 32x12 instance: zero-extended defaults, zeros above 15, wrap at 31
    wait_init("init5_wait", 60, 1'b1);
    rd5("p_rd3", 5'd3, 12'h014);
    rd5("p_rd20", 5'd20, 12'h000);
    bus5.en = 1'b1; bus5.rd_req = 1'b1; bus5.rd_addr = 5'd30; bus5.burst_len = 5'd2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus5.rd_req = 1'b0;
      chk_bit($sformatf("p_b%0d_vld", k), bus5.rd_valid, 1'b1);
      chk_dat($sformatf("p_b%0d_dat", k), bus5.rd_data, b5_dat[k]);
      chk_bit($sformatf("p_b%0d_busy", k), bus5.busy, b5_bsy[k]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ram_decode_seq.md
Name: ram_decode_seq

Overview:
- Parametrised successor to the 16×8 decode lookup table.
- Adds a runtime-writable table and a registered read path with a valid strobe.
- Adds auto-incrementing burst readout with wrap, and a reset-time init sequencer that reloads the default decode constants.
- Sits between the sequencing control and any datapath that needs decoded step/threshold values.

Parameters:
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries.
- DATA_W, 8, entry width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  block enable; gates reads, writes and burst progress
- wr_en  in  1  table write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_req  in  1  read/burst start request, sampled in IDLE only
- rd_addr  in  ADDR_W  start address of read/burst
- burst_len  in  ADDR_W  extra words after the first (0 = single read)
- rd_valid  out  1  rd_data valid this cycle
- rd_data  out  DATA_W  read data
- busy  out  1  high in INIT or BURST
- init_done  out  1  high once the table is loaded

Behaviour:
- Reset (async assert, sync release to clk):
  - state=INIT, init_ptr=0.
  - rd_valid=0, rd_data=0, busy=1, init_done=0.
- INIT:
  - Each cycle writes DEFAULT(init_ptr) to mem[init_ptr], then increments init_ptr. Independent of en.
  - After entry DEPTH-1 is written, goes to IDLE: init_done=1, busy=0. INIT lasts exactly DEPTH cycles.
  - rd_req and wr_en are ignored and dropped.
- DEFAULT(i), for i<16, in order:
  - 03,08,0D,14,19,1E,25,2A,2C,31,36,3D,46,50,59,6C (hex, 8-bit).
  - Zero-extended if DATA_W>8; low DATA_W bits kept if DATA_W<8.
  - DEFAULT(i)=0 for i≥16.
  - If ADDR_W<4, only the first DEPTH values are used.
- IDLE, en=1 and rd_req=1:
  - burst_len==0: next cycle rd_data=mem[rd_addr], rd_valid=1 for one cycle. Stay IDLE.
  - burst_len>0: capture ptr=rd_addr, remaining=burst_len, go to BURST, busy=1.
  - Read latency is 1 cycle from the request edge to rd_valid.
  - Back-to-back single reads give one word per cycle.
- BURST:
  - First word is valid the cycle after the request. One word per cycle while en=1.
  - ptr increments modulo DEPTH, e.g. DEPTH-1 → 0.
  - After burst_len+1 words, returns to IDLE; busy drops in the same cycle as the last rd_valid.
  - rd_req is ignored in BURST.
- en=0:
  - rd_valid=0, rd_data holds its last value.
  - Burst pointer and remaining count freeze; the burst resumes when en returns.
  - Writes are blocked.
- Writes:
  - Accepted in IDLE or BURST when en=1 and wr_en=1; take effect at the clock edge.
  - Same-cycle read of the same address returns the old data (read-first).
- Reset mid-burst or mid-INIT: burst aborted, table fully reloaded from DEFAULT, user writes lost.
- No X on outputs after reset; rd_data changes only on a valid read.

Decomposition:
- Package ram_decode_pkg:
  - DEFAULT_TABLE constant (16×8).
  - Function default_entry(i, DATA_W).
  - State enum {INIT, IDLE, BURST}.
- Sub-module ram_decode_mem:
  - DEPTH×DATA_W array, one write port, one synchronous read-first read port.
  - Carries no reset on the array.
- Top level holds the FSM, init/burst pointers and the output registers.

Test Plan:
- Init check: release rst_n → busy=1 for 16 cycles, then init_done=1. Single reads of addr 0,7,15 → rd_data 0x03, 0x2A, 0x6C, each with rd_valid one cycle after rd_req.
- Read during INIT: rd_req at cycle 3 after reset → no rd_valid at any point, and no stale burst state once IDLE is reached.
- Wrapping burst: rd_addr=14, burst_len=3 → rd_valid for 4 consecutive cycles with data 0x59, 0x6C, 0x03, 0x08. busy falls with the last word.
- Enable pause: burst from addr 0, burst_len=5, en=0 for 2 cycles after the 2nd word → sequence 03, 08, (gap 2 cycles, rd_data holds 0x08), 0D, 14, 19, 1E.
- Write then read: write 0xA5 to addr 5; same-cycle read of 5 → 0x1E; read on the next cycle → 0xA5. Pulse rst_n, re-init, read 5 → 0x1E.
- Parametric: ADDR_W=5, DATA_W=12 → addr 3 reads 0x014, addr 20 reads 0x000. Burst from 30 with burst_len=2 → 0x000, 0x000, 0x003.
